// File: rtl/vospi_pkg.sv
// Shared types and constants for the VoSPI pixel assembler slice.
package vospi_pkg;

  // Lepton VoSPI geometry: 160 payload bytes per packet, one packet per line.
  localparam int unsigned PAYLOAD_BYTES = 160;
  localparam int unsigned LINE_PIXELS   = PAYLOAD_BYTES / 2;
  localparam int unsigned FRAME_LINES   = 60;
  localparam int unsigned PIXEL_W       = 14;
  localparam int unsigned X_W           = $clog2(LINE_PIXELS);
  localparam int unsigned Y_W           = $clog2(FRAME_LINES);

  // Byte-pairing state: waiting for the MSB or for the LSB of a pixel word.
  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_e;

  // One assembled pixel together with its frame position tags.
  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               sof;
    logic               eof;
  } pixel_tag_t;

  // Smaller of two pixel values.
  function automatic logic [PIXEL_W-1:0] pix_min(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W-1:0] r;
    if (a < b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Larger of two pixel values.
  function automatic logic [PIXEL_W-1:0] pix_max(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W-1:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/vospi_pixel_fifo.sv
// Two-entry valid/ready FIFO of tagged pixels. Slot 0 is always the head, so
// the head and the status flags come straight out of flops. A push into a full
// FIFO is only lost when no pop happens in the same cycle.
module vospi_pixel_fifo
  import vospi_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  pixel_tag_t data_i,
  input  logic       pop_i,
  output pixel_tag_t head_o,
  output logic       valid_o,
  output logic       full_o
);

  pixel_tag_t slot0_q;
  pixel_tag_t slot1_q;
  logic       valid_q;
  logic       full_q;
  logic       pop_s;

  // A pop only means something when the head holds data.
  always_comb begin
    pop_s = 1'b0;
    if (valid_q) begin
      pop_s = pop_i;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Slot shifting and occupancy tracking.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      case ({push_i, pop_s})
        2'b11: begin
          if (full_q) begin
            slot0_q <= slot1_q;
            slot1_q <= data_i;
          end else begin
            slot0_q <= data_i;
          end
        end
        2'b10: begin
          if (!valid_q) begin
            slot0_q <= data_i;
            valid_q <= 1'b1;
          end else if (!full_q) begin
            slot1_q <= data_i;
            full_q  <= 1'b1;
          end else begin
            slot1_q <= slot1_q;
          end
        end
        2'b01: begin
          slot0_q <= slot1_q;
          valid_q <= full_q;
          full_q  <= 1'b0;
        end
        default: begin
          slot0_q <= slot0_q;
        end
      endcase
    end
  end

  assign head_o  = slot0_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/vospi_pixel_assembler.sv
// Pairs VoSPI payload bytes (MSB first) into Lepton pixels, tags them with
// column/row and frame markers, buffers them for a valid/ready consumer and
// publishes per-frame min/max for the downstream AGC stage. A long silence on
// the byte stream abandons the partial pixel and frame.
module vospi_pixel_assembler
  import vospi_pkg::*;
#(
  parameter int unsigned line_pixels_p = LINE_PIXELS,
  parameter int unsigned frame_lines_p = FRAME_LINES,
  parameter int unsigned pixel_width_p = PIXEL_W,
  parameter int unsigned gap_cycles_p  = 4096
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             clear_i,
  input  logic [7:0]                       data_i,
  input  logic                             valid_i,
  output logic [pixel_width_p-1:0]         pixel_o,
  output logic [$clog2(line_pixels_p)-1:0] x_o,
  output logic [$clog2(frame_lines_p)-1:0] y_o,
  output logic                             sof_o,
  output logic                             eof_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [pixel_width_p-1:0]         frame_min_o,
  output logic [pixel_width_p-1:0]         frame_max_o,
  output logic                             minmax_valid_o,
  output logic                             overflow_o
);

  localparam int unsigned XW     = $clog2(line_pixels_p);
  localparam int unsigned YW     = $clog2(frame_lines_p);
  localparam int unsigned IDLE_W = $clog2(gap_cycles_p + 1);

  localparam logic [XW-1:0]            X_LAST    = XW'(line_pixels_p - 1);
  localparam logic [YW-1:0]            Y_LAST    = YW'(frame_lines_p - 1);
  localparam logic [IDLE_W-1:0]        IDLE_LAST = IDLE_W'(gap_cycles_p - 1);
  localparam logic [pixel_width_p-1:0] MIN_INIT  = {pixel_width_p{1'b1}};

  asm_state_e                 state_q;
  logic [7:0]                 hi_q;
  logic [XW-1:0]              x_q;
  logic [YW-1:0]              y_q;
  logic [IDLE_W-1:0]          idle_q;
  logic [pixel_width_p-1:0]   min_q;
  logic [pixel_width_p-1:0]   max_q;
  logic [pixel_width_p-1:0]   frame_min_q;
  logic [pixel_width_p-1:0]   frame_max_q;
  logic                       minmax_valid_q;
  logic                       overflow_q;

  logic [pixel_width_p-1:0]   pix_s;
  logic [pixel_width_p-1:0]   min_next_s;
  logic [pixel_width_p-1:0]   max_next_s;
  logic                       sof_s;
  logic                       eof_s;
  logic                       assemble_s;
  logic                       idle_cond_s;
  logic                       pop_s;
  logic                       drop_s;
  logic                       fifo_valid_s;
  logic                       fifo_full_s;
  pixel_tag_t                 tag_s;
  pixel_tag_t                 head_s;

  // Pixel assembly, position markers and the push/drop decision.
  always_comb begin
    pix_s       = pixel_width_p'({hi_q, data_i});
    sof_s       = (x_q == '0) && (y_q == '0);
    eof_s       = (x_q == X_LAST) && (y_q == Y_LAST);
    min_next_s  = pix_min(min_q, pix_s);
    max_next_s  = pix_max(max_q, pix_s);
    idle_cond_s = (state_q == WAIT_LO) || !sof_s;
    pop_s       = fifo_valid_s && ready_i;
    if (clear_i) begin
      assemble_s = 1'b0;
    end else begin
      assemble_s = (state_q == WAIT_LO) && valid_i;
    end
    drop_s = assemble_s && fifo_full_s && !pop_s;
    tag_s  = '{pixel: pix_s, x: x_q, y: y_q, sof: sof_s, eof: eof_s};
  end

  vospi_pixel_fifo u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (clear_i),
    .push_i   (assemble_s),
    .data_i   (tag_s),
    .pop_i    (pop_s),
    .head_o   (head_s),
    .valid_o  (fifo_valid_s),
    .full_o   (fifo_full_s)
  );

  // Byte-pairing FSM with position, idle timeout, min/max and overflow state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= WAIT_HI;
      hi_q           <= 8'h00;
      x_q            <= '0;
      y_q            <= '0;
      idle_q         <= '0;
      min_q          <= MIN_INIT;
      max_q          <= '0;
      frame_min_q    <= '0;
      frame_max_q    <= '0;
      minmax_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (clear_i) begin
      // Restart wins over any byte arriving in the same cycle.
      state_q        <= WAIT_HI;
      hi_q           <= 8'h00;
      x_q            <= '0;
      y_q            <= '0;
      idle_q         <= '0;
      min_q          <= MIN_INIT;
      max_q          <= '0;
      minmax_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      minmax_valid_q <= 1'b0;
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
      if (valid_i) begin
        idle_q <= '0;
        case (state_q)
          WAIT_HI: begin
            hi_q    <= data_i;
            state_q <= WAIT_LO;
          end
          WAIT_LO: begin
            state_q <= WAIT_HI;
            if (eof_s) begin
              // Last pixel of the frame: publish stats including it, restart.
              x_q            <= '0;
              y_q            <= '0;
              frame_min_q    <= min_next_s;
              frame_max_q    <= max_next_s;
              minmax_valid_q <= 1'b1;
              min_q          <= MIN_INIT;
              max_q          <= '0;
            end else begin
              min_q <= min_next_s;
              max_q <= max_next_s;
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1'b1);
              end else begin
                x_q <= x_q + XW'(1'b1);
              end
            end
          end
          default: begin
            state_q <= WAIT_HI;
          end
        endcase
      end else if (idle_cond_s) begin
        if (idle_q == IDLE_LAST) begin
          // Stream went quiet mid-pixel or mid-frame: abandon it silently.
          state_q <= WAIT_HI;
          x_q     <= '0;
          y_q     <= '0;
          idle_q  <= '0;
          min_q   <= MIN_INIT;
          max_q   <= '0;
        end else begin
          idle_q <= idle_q + IDLE_W'(1'b1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign pixel_o        = head_s.pixel;
  assign x_o            = head_s.x;
  assign y_o            = head_s.y;
  assign sof_o          = head_s.sof;
  assign eof_o          = head_s.eof;
  assign valid_o        = fifo_valid_s;
  assign frame_min_o    = frame_min_q;
  assign frame_max_o    = frame_max_q;
  assign minmax_valid_o = minmax_valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_vospi_pixel_assembler.sv
// Self-checking bench for vospi_pixel_assembler: a frame-index based model
// with a 2-deep expected-pixel queue, compared every cycle, plus literal pins.
module tb_vospi_pixel_assembler;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        clear_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [13:0] pixel_o;
  logic [6:0]  x_o;
  logic [5:0]  y_o;
  logic        sof_o;
  logic        eof_o;
  logic        valid_o;
  logic        ready_i;
  logic [13:0] frame_min_o;
  logic [13:0] frame_max_o;
  logic        minmax_valid_o;
  logic        overflow_o;

  vospi_pixel_assembler dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .clear_i        (clear_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .pixel_o        (pixel_o),
    .x_o            (x_o),
    .y_o            (y_o),
    .sof_o          (sof_o),
    .eof_o          (eof_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .frame_min_o    (frame_min_o),
    .frame_max_o    (frame_max_o),
    .minmax_valid_o (minmax_valid_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int pix;
    int x;
    int y;
    bit sof;
    bit eof;
  } exp_t;

  exp_t mq[$];
  bit   m_have_hi;
  int   m_hi;
  int   m_idx;
  int   m_idle;
  int   m_mn;
  int   m_mx;
  int   m_fmin;
  int   m_fmax;
  bit   m_pulse;
  bit   m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_have_hi = 1'b0;
    m_hi      = 0;
    m_idx     = 0;
    m_idle    = 0;
    m_mn      = 16383;
    m_mx      = 0;
    m_fmin    = 0;
    m_fmax    = 0;
    m_pulse   = 1'b0;
    m_ovf     = 1'b0;
  endtask

  // One clock of behaviour from the frame-index view of the stream.
  task automatic model_step(input bit v, input int d, input bit r, input bit c);
    exp_t e;
    int   p;
    bit   pop;
    pop     = (mq.size() > 0) && r;
    m_pulse = 1'b0;
    if (c) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_have_hi = 1'b0;
      m_idx     = 0;
      m_idle    = 0;
      m_mn      = 16383;
      m_mx      = 0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (v) begin
      m_idle = 0;
      if (!m_have_hi) begin
        m_hi      = d;
        m_have_hi = 1'b1;
      end else begin
        p     = ((m_hi * 256) + d) % 16384;
        e.pix = p;
        e.x   = m_idx % 80;
        e.y   = m_idx / 80;
        e.sof = (m_idx == 0);
        e.eof = (m_idx == 4799);
        if (mq.size() < 2) mq.push_back(e);
        else m_ovf = 1'b1;
        if (p < m_mn) m_mn = p;
        if (p > m_mx) m_mx = p;
        if (e.eof) begin
          m_fmin  = m_mn;
          m_fmax  = m_mx;
          m_pulse = 1'b1;
          m_mn    = 16383;
          m_mx    = 0;
        end
        m_idx     = (m_idx + 1) % 4800;
        m_have_hi = 1'b0;
      end
    end else if (m_have_hi || m_idx != 0) begin
      m_idle++;
      if (m_idle == 4096) begin
        m_have_hi = 1'b0;
        m_idx     = 0;
        m_idle    = 0;
        m_mn      = 16383;
        m_mx      = 0;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic compare_all();
    check("valid_o", valid_o, (mq.size() > 0));
    if (mq.size() > 0) begin
      check("pixel_o", pixel_o, mq[0].pix);
      check("x_o", x_o, mq[0].x);
      check("y_o", y_o, mq[0].y);
      check("sof_o", sof_o, mq[0].sof);
      check("eof_o", eof_o, mq[0].eof);
    end
    check("minmax_valid_o", minmax_valid_o, m_pulse);
    check("frame_min_o", frame_min_o, m_fmin);
    check("frame_max_o", frame_max_o, m_fmax);
    check("overflow_o", overflow_o, m_ovf);
  endtask

  // Called at a falling edge: drive, clock, update model, compare at next fall.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    clear_i = c;
    @(posedge clk_i);
    #1;
    model_step(v, int'(d), r, c);
    valid_i = 1'b0;
    clear_i = 1'b0;
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic send_pix(input logic [15:0] w, input bit r);
    cyc(1'b1, w[15:8], r, 1'b0);
    cyc(1'b1, w[7:0], r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, r, 1'b0);
  endtask

  initial begin
    reset_ni = 1'b0;
    clear_i  = 1'b0;
    data_i   = 8'h00;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    compare_all();
    check("rst_valid", valid_o, 0);
    check("rst_pixel", pixel_o, 0);
    check("rst_min", frame_min_o, 0);
    check("rst_max", frame_max_o, 0);

    // Two basic pixels; upper two bits of the second word are discarded.
    send_pix(16'h3FFF, 1'b1);
    check("p1_valid", valid_o, 1);
    check("p1_pixel", pixel_o, 14'h3FFF);
    check("p1_sof", sof_o, 1);
    check("p1_x", x_o, 0);
    send_pix(16'hC123, 1'b1);
    check("p2_pixel", pixel_o, 14'h0123);
    check("p2_x", x_o, 1);
    check("p2_y", y_o, 0);
    check("p2_sof", sof_o, 0);
    idle(2, 1'b1);

    // Whole frame with value = y*80+x, then the first pixel of the next frame.
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4800; i++) begin
      send_pix(16'(i), 1'b1);
      if (i == 79) begin
        check("fr_x79", x_o, 79);
        check("fr_y0", y_o, 0);
      end
      if (i == 80) begin
        check("fr_x0", x_o, 0);
        check("fr_y1", y_o, 1);
      end
      if (i == 4799) begin
        check("fr_eof", eof_o, 1);
        check("fr_eof_x", x_o, 79);
        check("fr_eof_y", y_o, 59);
        check("fr_mm_pulse", minmax_valid_o, 1);
        check("fr_min", frame_min_o, 0);
        check("fr_max", frame_max_o, 4799);
      end
      idle(2, 1'b1);
    end
    send_pix(16'h0042, 1'b1);
    check("fr_next_sof", sof_o, 1);
    check("fr_next_pix", pixel_o, 14'h0042);
    idle(2, 1'b1);

    // Buffer overflow with the consumer stalled.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    send_pix(16'h0011, 1'b0);
    send_pix(16'h0022, 1'b0);
    send_pix(16'h0033, 1'b0);
    check("ov_flag", overflow_o, 1);
    check("ov_head", pixel_o, 14'h0011);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("ov_second", pixel_o, 14'h0022);
    check("ov_second_x", x_o, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("ov_drained", valid_o, 0);
    check("ov_sticky", overflow_o, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check("ov_cleared", overflow_o, 0);

    // Gap timeout after a lone high byte.
    cyc(1'b1, 8'h12, 1'b1, 1'b0);
    idle(4096, 1'b1);
    send_pix(16'h0005, 1'b1);
    check("gap_pix", pixel_o, 14'h0005);
    check("gap_sof", sof_o, 1);
    check("gap_x", x_o, 0);
    check("gap_mm", minmax_valid_o, 0);
    idle(2, 1'b1);

    // Asynchronous reset with two pixels buffered and a half pixel pending.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    send_pix(16'h0101, 1'b0);
    send_pix(16'h0202, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    check("ar_pre_valid", valid_o, 1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("ar_valid_now", valid_o, 0);
    model_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;
    compare_all();
    send_pix(16'h0404, 1'b1);
    check("ar_pix", pixel_o, 14'h0404);
    check("ar_sof", sof_o, 1);
    check("ar_x", x_o, 0);
    idle(2, 1'b1);

    // Clear coinciding with a low byte drops that byte and rewinds position.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, 8'h66, 1'b1, 1'b1);
    check("cl_no_pix", valid_o, 0);
    send_pix(16'h2BCD, 1'b1);
    check("cl_pix", pixel_o, 14'h2BCD);
    check("cl_x", x_o, 0);
    check("cl_y", y_o, 0);
    check("cl_sof", sof_o, 1);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
